msg_beat_deframer: RTL and testbench

MSG_BEAT_DEFRAMER -- requirements
Module: msg_beat_deframer

---
 rtl/msg_beat_deframer.sv | 121 ++++++++++++
 tb/tb_msg_beat_deframer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_beat_deframer.sv
// rtl/msg_beat_deframer.sv - splits header+payload beat messages into a tagged payload FIFO
// Oversize messages are swallowed whole; each FIFO entry carries its own method and first/last tags.
module msg_beat_deframer #(
  parameter int DEPTH     = 8,
  parameter int MAX_WORDS = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_src_rdy,
  input  logic [31:0] in_beat,
  output logic        in_dst_rdy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] out_method,
  output logic        out_first,
  output logic        out_last,
  output logic        err_len,
  output logic [31:0] msg_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {HDR, BODY, DISCARD} state_t;

  state_t        state, nextState;
  logic [15:0]   remaining, nextRemaining;
  logic [15:0]   msgLen, method;
  logic [15:0]   hdrLen;
  logic [AW:0]   count;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [49:0]   mem [DEPTH];
  logic          fifoFull, xfer, push, pop, msgDone, hdrOver, nextErr;

  assign hdrLen   = in_beat[15:0];
  assign hdrOver  = {1'b0, hdrLen} > 17'(MAX_WORDS);
  assign fifoFull = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;
  // Ready depends only on registered state (and reset), never on the handshake inputs.
  assign in_dst_rdy = !RST && ((state != BODY) || !fifoFull);
  assign xfer     = in_src_rdy && in_dst_rdy;

  always_comb begin
    nextState     = state;
    nextRemaining = remaining;
    push          = 1'b0;
    msgDone       = 1'b0;
    nextErr       = 1'b0;
    case (state)
      HDR: begin
        if (xfer) begin
          if (hdrLen == 16'd0) begin
            msgDone = 1'b1;
          end else if (hdrOver) begin
            nextErr       = 1'b1;
            nextState     = DISCARD;
            nextRemaining = hdrLen;
          end else begin
            nextState     = BODY;
            nextRemaining = hdrLen;
          end
        end
      end
      BODY: begin
        if (xfer) begin
          push          = 1'b1;
          nextRemaining = remaining - 16'd1;
          if (remaining == 16'd1) begin
            msgDone   = 1'b1;
            nextState = HDR;
          end
        end
      end
      DISCARD: begin
        if (xfer) begin
          nextRemaining = remaining - 16'd1;
          if (remaining == 16'd1) nextState = HDR;
        end
      end
      default: nextState = HDR;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= HDR;
      remaining <= '0;
      msgLen    <= '0;
      method    <= '0;
      err_len   <= 1'b0;
      msg_count <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
    end else begin
      state     <= nextState;
      remaining <= nextRemaining;
      err_len   <= nextErr;
      if (msgDone) msg_count <= msg_count + 32'd1;
      if (state == HDR && xfer) begin
        method <= in_beat[31:16];
        msgLen <= hdrLen;
      end
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= {in_beat, method, remaining == msgLen, remaining == 16'd1};
  end

  assign {out_data, out_method, out_first, out_last} = mem[rdPtr];

endmodule

// File: tb/tb_msg_beat_deframer.sv
// tb/tb_msg_beat_deframer.sv - table-driven and scoreboard bench for msg_beat_deframer
// Expected payload entries are queued as beats are driven and checked on each pop.
module tb_msg_beat_deframer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_src_rdy;
  logic [31:0] in_beat;
  logic        in_dst_rdy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_method;
  logic        out_first;
  logic        out_last;
  logic        err_len;
  logic [31:0] msg_count;

  msg_beat_deframer #(.DEPTH(8), .MAX_WORDS(255)) dut (
    .CLK(CLK), .RST(RST), .in_src_rdy(in_src_rdy), .in_beat(in_beat),
    .in_dst_rdy(in_dst_rdy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_method(out_method), .out_first(out_first),
    .out_last(out_last), .err_len(err_len), .msg_count(msg_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] method;
    logic        first;
    logic        last;
  } ent_t;

  typedef struct {
    logic [31:0] hdr;
    int          beats;
    int          expPushes;
    int          expErr;
    int          msgInc;
  } vec_t;

  ent_t expq[$];
  ent_t monEnt;
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   popCount = 0;
  int   errPulses = 0;
  int   expMsgs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && err_len) errPulses++;
    if (!RST && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data 0x%0h expected no pop", out_data);
      end else begin
        monEnt = expq.pop_front();
        chk("pop_data", out_data, monEnt.data);
        chk("pop_method", {16'h0, out_method}, {16'h0, monEnt.method});
        chk("pop_first", 32'(out_first), 32'(monEnt.first));
        chk("pop_last", 32'(out_last), 32'(monEnt.last));
      end
      popCount++;
    end
  end

  task automatic sendBeat(input logic [31:0] b);
    int n = 0;
    in_beat    = b;
    in_src_rdy = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!in_dst_rdy && n < 200);
    if (!in_dst_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_dst_rdy 0 expected 1 for beat 0x%0h", b);
    end
    @(posedge CLK);
    #1;
    in_src_rdy = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    @(posedge CLK);
    #1;
    chk("drain_done", 32'(expq.size()), 32'd0);
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int popBefore;
    int errBefore;

    RST        = 1'b1;
    in_src_rdy = 1'b0;
    in_beat    = '0;
    out_ready  = 1'b1;
    #2;
    chk("rst_dst_rdy", 32'(in_dst_rdy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_msg_count", msg_count, 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rel_dst_rdy", 32'(in_dst_rdy), 32'd1);

    vecs[0] = '{32'h0007_0003,   3,   3, 0, 1};
    vecs[1] = '{32'h0002_0000,   0,   0, 0, 1};
    vecs[2] = '{32'h0001_0100, 256,   0, 1, 0};
    vecs[3] = '{32'h0006_0002,   2,   2, 0, 1};
    vecs[4] = '{32'h00AB_0001,   1,   1, 0, 1};
    vecs[5] = '{32'h0055_00FF, 255, 255, 0, 1};

    foreach (vecs[i]) begin
      popBefore = popCount;
      errBefore = errPulses;
      sendBeat(vecs[i].hdr);
      for (int j = 0; j < vecs[i].beats; j++) begin
        d = $urandom;
        if (vecs[i].expPushes != 0)
          expq.push_back({d, vecs[i].hdr[31:16], j == 0, j == vecs[i].beats - 1});
        sendBeat(d);
      end
      expMsgs += vecs[i].msgInc;
      drain();
      chk("vec_pops", 32'(popCount - popBefore), 32'(vecs[i].expPushes));
      chk("vec_err_pulses", 32'(errPulses - errBefore), 32'(vecs[i].expErr));
      chk("vec_msg_count", msg_count, 32'(expMsgs));
    end

    // Full FIFO backpressure, a single-cycle pop, then the refused push completing.
    out_ready = 1'b0;
    sendBeat(32'h0005_000A);
    for (int j = 0; j < 8; j++) begin
      d = 32'hA000_0000 + 32'(j);
      expq.push_back({d, 16'h0005, j == 0, 1'b0});
      sendBeat(d);
    end
    d = 32'hA000_0008;
    expq.push_back({d, 16'h0005, 1'b0, 1'b0});
    in_beat    = d;
    in_src_rdy = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("full_dst_rdy_low", 32'(in_dst_rdy), 32'd0);
      chk("full_head_stable", out_data, 32'hA000_0000);
    end
    popBefore = popCount;
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("full_pop_refuse", 32'(in_dst_rdy), 32'd0);
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk("single_pop", 32'(popCount - popBefore), 32'd1);
    @(negedge CLK);
    chk("rdy_after_pop", 32'(in_dst_rdy), 32'd1);
    @(posedge CLK);
    #1;
    in_src_rdy = 1'b0;
    @(negedge CLK);
    chk("full_again", 32'(in_dst_rdy), 32'd0);
    out_ready = 1'b1;
    d = 32'hA000_0009;
    expq.push_back({d, 16'h0005, 1'b0, 1'b1});
    sendBeat(d);
    expMsgs++;
    drain();
    chk("full_msg_count", msg_count, 32'(expMsgs));

    // Two messages coexisting in the FIFO before draining.
    out_ready = 1'b0;
    sendBeat(32'h0003_0002);
    expq.push_back({32'hB000_0001, 16'h0003, 1'b1, 1'b0});
    sendBeat(32'hB000_0001);
    expq.push_back({32'hB000_0002, 16'h0003, 1'b0, 1'b1});
    sendBeat(32'hB000_0002);
    sendBeat(32'h0004_0001);
    expq.push_back({32'hB000_0003, 16'h0004, 1'b1, 1'b1});
    sendBeat(32'hB000_0003);
    expMsgs += 2;
    @(negedge CLK);
    chk("b2b_msg_count", msg_count, 32'(expMsgs));
    chk("b2b_valid", 32'(out_valid), 32'd1);
    drain();

    // Reset mid-message, checked without any clock edge.
    out_ready = 1'b0;
    sendBeat(32'h0008_0005);
    sendBeat(32'hC000_0001);
    sendBeat(32'hC000_0002);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_msg_count", msg_count, 32'd0);
    chk("mid_rst_dst_rdy", 32'(in_dst_rdy), 32'd0);
    expMsgs = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    out_ready = 1'b1;
    popBefore = popCount;
    sendBeat(32'h0009_0001);
    expq.push_back({32'hD00D_0001, 16'h0009, 1'b1, 1'b1});
    sendBeat(32'hD00D_0001);
    expMsgs = 1;
    drain();
    chk("post_rst_pops", 32'(popCount - popBefore), 32'd1);
    chk("post_rst_msg_count", msg_count, 32'(expMsgs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
